// File: rtl/vector_dispatch_pkg.sv
// Shared definitions for the scalar-to-vector dispatch stage: sizing,
// the to_vector instruction record, SEW encodings and vtype field offsets.
package vector_dispatch_pkg;

  localparam int VECTOR_LANES = 8;
  localparam int VL_WIDTH     = $clog2(32 * VECTOR_LANES);
  localparam int DATA_WIDTH   = 32;

  // SEW codes carried in immediate[5:3] of vset{i}vl{i}
  localparam logic [2:0] SEW8  = 3'd0;
  localparam logic [2:0] SEW16 = 3'd1;
  localparam logic [2:0] SEW32 = 3'd2;

  // vtype field offsets inside the immediate
  localparam int VTYPE_SEW_LSB = 3;
  localparam int VTYPE_SEW_MSB = 5;

  // Decoded vector instruction as handed to the vector unit
  typedef struct packed {
    logic [6:0]            opcode;
    logic                  reconfigure;
    logic [4:0]            dst;
    logic [4:0]            src1;
    logic [4:0]            src2;
    logic [10:0]           immediate;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
    logic [VL_WIDTH-1:0]   vl;
    logic [VL_WIDTH-1:0]   maxvl;
  } to_vector;

endpackage

// File: rtl/vector_dispatch_vl_calc.sv
// Combinational vl/maxvl computation for vset{i}vl{i}.
// maxvl = VECTOR_LANES*32/SEW; vl = min(AVL, maxvl); illegal SEW gives 0/0.
module vector_dispatch_vl_calc
  import vector_dispatch_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic                  src1_zero,
  input  logic                  dst_zero,
  input  logic [2:0]            sew_code,
  input  logic [VL_WIDTH-1:0]   cur_vl,
  output logic [VL_WIDTH-1:0]   vl,
  output logic [VL_WIDTH-1:0]   maxvl,
  output logic                  illegal
);

  logic [DATA_WIDTH-1:0] avl;

  // Decode SEW, select AVL and clamp it against maxvl
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    illegal = 1'b0;
    maxvl   = '0;
    vl      = '0;
    avl     = '0;
    case (sew_code)
      SEW8:    maxvl = VL_WIDTH'(VECTOR_LANES << 2);
      SEW16:   maxvl = VL_WIDTH'(VECTOR_LANES << 1);
      SEW32:   maxvl = VL_WIDTH'(VECTOR_LANES);
      default: illegal = 1'b1;
    endcase
    if (src1_zero) begin
      // rs1=x0: rd!=x0 requests maxvl, rd=x0 keeps the current vl
      avl = dst_zero ? DATA_WIDTH'(cur_vl) : DATA_WIDTH'(maxvl);
    end else begin
      avl = data1;
    end
    if (!illegal) begin
      vl = (avl < DATA_WIDTH'(maxvl)) ? VL_WIDTH'(avl) : maxvl;
    end
  end

endmodule

// File: rtl/vector_dispatch.sv
// Scalar-to-vector dispatch: 2-entry full-throughput skid queue in front of
// the vector unit, vl/maxvl configuration registers and vl writeback.
// Optional performance counters are enabled with VECTOR_DISPATCH_PERF_EN.
module vector_dispatch
  import vector_dispatch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  to_vector              issue_instr_i,
  input  logic [4:0]            issue_rd_i,
  output logic                  vector_valid_o,
  input  logic                  vector_ready_i,
  output to_vector              vector_instruction_o,
  output logic                  rd_wb_valid_o,
  output logic [4:0]            rd_wb_addr_o,
  output logic [DATA_WIDTH-1:0] rd_wb_data_o,
  output logic                  vill_o
`ifdef VECTOR_DISPATCH_PERF_EN
  ,
  output logic [31:0]           perf_dispatched_o,
  output logic [31:0]           perf_stall_o,
  output logic [15:0]           perf_reconf_o
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]          state_q, state_d;
  to_vector            head_q, tail_q, new_entry;
  logic [VL_WIDTH-1:0] cfg_vl_q, cfg_maxvl_q;
  logic [VL_WIDTH-1:0] calc_vl, calc_maxvl;
  logic                calc_illegal;
  logic                accept, pop, reconf_accept;
  logic                load_head, load_tail, head_from_tail;

  // A flush kills any accept offered in the same cycle
  assign accept         = issue_valid_i & issue_ready_o & ~flush_i;
  assign pop            = vector_valid_o & vector_ready_i;
  assign reconf_accept  = accept & issue_instr_i.reconfigure;
  assign vector_valid_o = (state_q != ST_EMPTY);
  assign vector_instruction_o = head_q;

  vector_dispatch_vl_calc u_vl_calc (
    .data1     (issue_instr_i.data1),
    .src1_zero (issue_instr_i.src1 == 5'd0),
    .dst_zero  (issue_instr_i.dst == 5'd0),
    .sew_code  (issue_instr_i.immediate[VTYPE_SEW_MSB:VTYPE_SEW_LSB]),
    .cur_vl    (cfg_vl_q),
    .vl        (calc_vl),
    .maxvl     (calc_maxvl),
    .illegal   (calc_illegal)
  );

  // Incoming entry with vl/maxvl filled in; config regs already hold any
  // reconfigure accepted last cycle, so back-to-back followers see it.
  always_comb begin
    new_entry = issue_instr_i;
    if (issue_instr_i.reconfigure) begin
      new_entry.vl    = calc_vl;
      new_entry.maxvl = calc_maxvl;
    end else begin
      new_entry.vl    = cfg_vl_q;
      new_entry.maxvl = cfg_maxvl_q;
    end
  end

  // Queue FSM: next state and which slot is written
  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d   = ST_ONE;
          load_head = 1'b1;
        end
        ST_ONE: begin
          case ({accept, pop})
            2'b11:   load_head = 1'b1;
            2'b10:   begin state_d = ST_TWO; load_tail = 1'b1; end
            2'b01:   state_d = ST_EMPTY;
            default: state_d = ST_ONE;
          endcase
        end
        ST_TWO: if (pop) begin
          state_d        = ST_ONE;
          head_from_tail = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Queue state, registered ready and the head slot (drives the output)
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      issue_ready_o <= 1'b0;
      head_q        <= '0;
    end else begin
      state_q       <= state_d;
      issue_ready_o <= (state_d != ST_TWO);
      if (load_head) begin
        head_q <= new_entry;
      end else if (head_from_tail) begin
        head_q <= tail_q;
      end
    end
  end

  // Second slot payload; only read when the FSM says it is occupied
  always_ff @(posedge clk) begin
    // NOTE: storage-only slot left unreset; its occupancy lives in state_q.
    if (load_tail) begin
      tail_q <= new_entry;
    end
  end

  // Configuration registers and sticky vill, updated on reconfigure accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_vl_q    <= '0;
      cfg_maxvl_q <= '0;
      vill_o      <= 1'b0;
    end else if (reconf_accept) begin
      cfg_vl_q    <= calc_vl;
      cfg_maxvl_q <= calc_maxvl;
      vill_o      <= calc_illegal;
    end
  end

  // One-cycle writeback of the new vl to the scalar register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wb_valid_o <= 1'b0;
      rd_wb_addr_o  <= '0;
      rd_wb_data_o  <= '0;
    end else begin
      rd_wb_valid_o <= reconf_accept & (issue_rd_i != 5'd0);
      if (reconf_accept & (issue_rd_i != 5'd0)) begin
        rd_wb_addr_o <= issue_rd_i;
        rd_wb_data_o <= DATA_WIDTH'(calc_vl);
      end
    end
  end

`ifdef VECTOR_DISPATCH_PERF_EN
  // Free-running event counters; flush leaves them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dispatched_o <= '0;
      perf_stall_o      <= '0;
      perf_reconf_o     <= '0;
    end else begin
      if (pop)                              perf_dispatched_o <= perf_dispatched_o + 32'd1;
      if (vector_valid_o & !vector_ready_i) perf_stall_o      <= perf_stall_o + 32'd1;
      if (reconf_accept)                    perf_reconf_o     <= perf_reconf_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_dispatch.sv
// Self-checking bench for vector_dispatch: per-cycle vector table plus
// hand-written reset and streaming sequences (perf checks with
// VECTOR_DISPATCH_PERF_EN).
module tb_vector_dispatch;
  import vector_dispatch_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush_i;
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  to_vector              issue_instr_i;
  logic [4:0]            issue_rd_i;
  logic                  vector_valid_o;
  logic                  vector_ready_i;
  to_vector              vector_instruction_o;
  logic                  rd_wb_valid_o;
  logic [4:0]            rd_wb_addr_o;
  logic [DATA_WIDTH-1:0] rd_wb_data_o;
  logic                  vill_o;
`ifdef VECTOR_DISPATCH_PERF_EN
  logic [31:0]           perf_dispatched_o;
  logic [31:0]           perf_stall_o;
  logic [15:0]           perf_reconf_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vector_dispatch dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush_i              (flush_i),
    .issue_valid_i        (issue_valid_i),
    .issue_ready_o        (issue_ready_o),
    .issue_instr_i        (issue_instr_i),
    .issue_rd_i           (issue_rd_i),
    .vector_valid_o       (vector_valid_o),
    .vector_ready_i       (vector_ready_i),
    .vector_instruction_o (vector_instruction_o),
    .rd_wb_valid_o        (rd_wb_valid_o),
    .rd_wb_addr_o         (rd_wb_addr_o),
    .rd_wb_data_o         (rd_wb_data_o),
    .vill_o               (vill_o)
`ifdef VECTOR_DISPATCH_PERF_EN
    ,
    .perf_dispatched_o    (perf_dispatched_o),
    .perf_stall_o         (perf_stall_o),
    .perf_reconf_o        (perf_reconf_o)
`endif
  );

  // One row = inputs for one cycle + outputs expected before that cycle's edge
  typedef struct {
    logic        flush, iv, rc;
    logic [2:0]  sew;
    logic [4:0]  src1, dst;
    logic [31:0] d1;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic        vr;
    logic        e_ird, e_vv;
    logic [6:0]  e_op;
    logic [7:0]  e_vl, e_mvl;
    logic        e_wbv;
    logic [4:0]  e_wba;
    logic [31:0] e_wbd;
    logic        e_vill;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  function automatic vec_t mk(int flush, int iv, int rc, int sew, int src1, int dst, int d1, int op, int rd, int vr,
                              int e_ird, int e_vv, int e_op, int e_vl, int e_mvl, int e_wbv, int e_wba, int e_wbd, int e_vill);
    vec_t v;
    v.flush = flush[0]; v.iv = iv[0]; v.rc = rc[0]; v.sew = sew[2:0];
    v.src1 = src1[4:0]; v.dst = dst[4:0]; v.d1 = d1; v.op = op[6:0]; v.rd = rd[4:0]; v.vr = vr[0];
    v.e_ird = e_ird[0]; v.e_vv = e_vv[0]; v.e_op = e_op[6:0]; v.e_vl = e_vl[7:0]; v.e_mvl = e_mvl[7:0];
    v.e_wbv = e_wbv[0]; v.e_wba = e_wba[4:0]; v.e_wbd = e_wbd; v.e_vill = e_vill[0];
    return v;
  endfunction

  function automatic to_vector mk_instr(logic rc, logic [2:0] sew, logic [4:0] src1, logic [4:0] dst,
                                        logic [31:0] d1, logic [6:0] op);
    to_vector t;
    t             = '0;
    t.opcode      = op;
    t.reconfigure = rc;
    t.src1        = src1;
    t.dst         = dst;
    t.src2        = 5'd17;
    t.immediate   = {5'b00000, sew, 3'b011};
    t.data1       = d1;
    t.data2       = 32'hdead_beef;
    t.vl          = 8'hAA;   // must be ignored on input
    t.maxvl       = 8'h55;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic flush, input logic iv, input logic rc, input logic [2:0] sew,
                       input logic [4:0] src1, input logic [4:0] dst, input logic [31:0] d1,
                       input logic [6:0] op, input logic [4:0] rd, input logic vr);
    flush_i        = flush;
    issue_valid_i  = iv;
    issue_instr_i  = mk_instr(rc, sew, src1, dst, d1, op);
    issue_rd_i     = rd;
    vector_ready_i = vr;
  endtask

  task automatic idle(input logic vr);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 32'd0, 7'd0, 5'd0, vr);
  endtask

  initial begin
    //          fl iv rc sew s1 dst d1  op rd vr | ird vv op vl mvl wbv wba wbd vill
    tbl[0]  = mk(0, 1, 1, 2, 1, 5, 20,  1, 5, 1,  1, 0,  0,  0,  0, 0, 0,  0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 3, 99,  2, 3, 1,  1, 1,  1,  8,  8, 1, 5,  8, 0);
    tbl[2]  = mk(0, 1, 0, 0, 2, 4, 0,   3, 0, 1,  1, 1,  2, 32, 32, 1, 3, 32, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 1,  1, 1,  3, 32, 32, 0, 0,  0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 2, 4, 0,   4, 0, 0,  1, 0,  0,  0,  0, 0, 0,  0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 2, 4, 0,   5, 0, 0,  1, 1,  4, 32, 32, 0, 0,  0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 2, 4, 0,   6, 0, 0,  0, 1,  4, 32, 32, 0, 0,  0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 2, 4, 0,   6, 0, 0,  0, 1,  4, 32, 32, 0, 0,  0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 2, 4, 0,   6, 0, 0,  0, 1,  4, 32, 32, 0, 0,  0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 2, 4, 0,   6, 0, 1,  0, 1,  4, 32, 32, 0, 0,  0, 0);
    tbl[10] = mk(0, 1, 0, 0, 2, 4, 0,   6, 0, 1,  1, 1,  5, 32, 32, 0, 0,  0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 1,  1, 1,  6, 32, 32, 0, 0,  0, 0);
    tbl[12] = mk(0, 1, 1, 3, 1, 7, 10,  7, 7, 0,  1, 0,  0,  0,  0, 0, 0,  0, 0);
    tbl[13] = mk(0, 1, 1, 1, 1, 8, 4,   8, 8, 1,  1, 1,  7,  0,  0, 1, 7,  0, 1);
    tbl[14] = mk(0, 1, 0, 0, 2, 4, 0,   9, 0, 0,  1, 1,  8,  4, 16, 1, 8,  4, 0);
    tbl[15] = mk(1, 1, 1, 0, 1, 1, 1,  10, 1, 0,  0, 1,  8,  4, 16, 0, 0,  0, 0);
    tbl[16] = mk(0, 1, 0, 0, 2, 4, 0,  11, 0, 0,  1, 0,  0,  0,  0, 0, 0,  0, 0);
    tbl[17] = mk(1, 1, 1, 0, 1, 1, 1,  12, 1, 0,  1, 1, 11,  4, 16, 0, 0,  0, 0);
    tbl[18] = mk(0, 1, 0, 0, 2, 4, 0,  13, 0, 1,  1, 0,  0,  0,  0, 0, 0,  0, 0);
    tbl[19] = mk(0, 1, 1, 2, 0, 0, 77, 14, 9, 1,  1, 1, 13,  4, 16, 0, 0,  0, 0);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 1,  1, 1, 14,  4,  8, 1, 9,  4, 0);
    tbl[21] = mk(0, 1, 1, 0, 0, 0, 0,  15, 0, 1,  1, 0,  0,  0,  0, 0, 0,  0, 0);
    tbl[22] = mk(0, 1, 1, 0, 1, 2, 100,16, 2, 1,  1, 1, 15,  4, 32, 0, 0,  0, 0);
    tbl[23] = mk(0, 1, 1, 2, 0, 0, 0,  17, 4, 1,  1, 1, 16, 32, 32, 1, 2, 32, 0);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 1,  1, 1, 17,  8,  8, 1, 4,  8, 0);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 1,  1, 0,  0,  0,  0, 0, 0,  0, 0);

    rst_n = 1'b0;
    idle(1'b0);
    repeat (2) @(negedge clk);
    check("reset ctrl", {issue_ready_o, vector_valid_o, rd_wb_valid_o, vill_o}, 4'b0000);
    check("reset instr", vector_instruction_o, '0);
    check("reset wb", {rd_wb_addr_o, rd_wb_data_o}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].flush, tbl[i].iv, tbl[i].rc, tbl[i].sew, tbl[i].src1, tbl[i].dst,
            tbl[i].d1, tbl[i].op, tbl[i].rd, tbl[i].vr);
      check($sformatf("row%0d ctrl", i), {issue_ready_o, vector_valid_o, rd_wb_valid_o, vill_o},
            {tbl[i].e_ird, tbl[i].e_vv, tbl[i].e_wbv, tbl[i].e_vill});
      if (tbl[i].e_vv)
        check($sformatf("row%0d head", i),
              {vector_instruction_o.opcode, vector_instruction_o.vl, vector_instruction_o.maxvl},
              {tbl[i].e_op, tbl[i].e_vl, tbl[i].e_mvl});
      if (tbl[i].e_wbv)
        check($sformatf("row%0d wb", i), {rd_wb_addr_o, rd_wb_data_o}, {tbl[i].e_wba, tbl[i].e_wbd});
    end

    // Fill to TWO, then assert reset between edges
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 3'd2, 5'd1, 5'd6, 32'd5, 7'd20, 5'd6, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 5'd2, 5'd4, 32'd0, 7'd21, 5'd0, 1'b0);
    @(negedge clk);
    idle(1'b0);
    check("pre-reset two", {issue_ready_o, vector_valid_o, vector_instruction_o.opcode,
          vector_instruction_o.vl, vector_instruction_o.maxvl}, {1'b0, 1'b1, 7'd20, 8'd5, 8'd8});
    #2 rst_n = 1'b0;
    #1;
    check("async reset ctrl", {issue_ready_o, vector_valid_o, rd_wb_valid_o, vill_o}, 4'b0000);
    check("async reset instr", vector_instruction_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset ready", {issue_ready_o, vector_valid_o}, 2'b10);

    // Ten back-to-back instructions; first keeps vl (cleared by reset)
    for (int i = 0; i < 10; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 1'b1, 3'd0, 5'd0, 5'd0, 32'd0, 7'd22, 5'd0, 1'b1);
      else        drive(1'b0, 1'b1, 1'b0, 3'd0, 5'd2, 5'd4, 32'd0, 7'(30 + i), 5'd0, 1'b1);
      if (i == 0)
        check("stream start", {issue_ready_o, vector_valid_o}, 2'b10);
      else
        check($sformatf("stream%0d head", i), {issue_ready_o, vector_valid_o, vector_instruction_o.opcode,
              vector_instruction_o.vl, vector_instruction_o.maxvl},
              {1'b1, 1'b1, (i == 1) ? 7'd22 : 7'(30 + i - 1), 8'd0, 8'd32});
      @(negedge clk);
    end
    idle(1'b1);
    check("stream last", {vector_valid_o, vector_instruction_o.opcode}, {1'b1, 7'd39});
    @(negedge clk);
    check("stream drained", {issue_ready_o, vector_valid_o}, 2'b10);
`ifdef VECTOR_DISPATCH_PERF_EN
    check("perf dispatched", perf_dispatched_o, 32'd10);
    check("perf stall", perf_stall_o, 32'd0);
    check("perf reconf", perf_reconf_o, 16'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
